// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the D-stage hazard controller: result classes,
// forwarding-mux select codes and result latencies.
package hazard_ctrl_pkg;

  localparam int RES_W = 3;

  // Result class of an instruction; nw means "writes no register".
  typedef enum logic [RES_W-1:0] {
    RES_NW    = 3'd0,
    RES_ALU   = 3'd1,
    RES_DM    = 3'd2,
    RES_PC    = 3'd3,
    RES_OTHER = 3'd4
  } res_t;

  // Forwarding-mux select codes shared by every operand mux.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_t;

  // Cycles, counted from E, until a producer's result exists.
  localparam int TNEW_DM  = 2;
  localparam int TNEW_ALU = 1;

  // tnew of an instruction as it enters E.
  function automatic logic [1:0] tnew_of(input logic [RES_W-1:0] res);
    case (res)
      RES_DM:  return 2'(TNEW_DM);
      RES_ALU: return 2'(TNEW_ALU);
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_stage.sv
// One scoreboard entry {dst, tnew, res, rs, rt}. Loads the upstream entry
// each cycle, optionally ageing tnew by one, or loads a bubble instead.
module hz_stage_reg
  import hazard_ctrl_pkg::*;
#(
  parameter int REGW = 5,
  parameter int TW   = 2,
  parameter bit DECR = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bubble_i,
  input  logic [REGW-1:0]  dst_i,
  input  logic [TW-1:0]    tnew_i,
  input  logic [RES_W-1:0] res_i,
  input  logic [REGW-1:0]  rs_i,
  input  logic [REGW-1:0]  rt_i,
  output logic [REGW-1:0]  dst_o,
  output logic [TW-1:0]    tnew_o,
  output logic [RES_W-1:0] res_o,
  output logic [REGW-1:0]  rs_o,
  output logic [REGW-1:0]  rt_o
);

  logic [REGW-1:0]  dst_q, dst_d;
  logic [TW-1:0]    tnew_q, tnew_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [REGW-1:0]  rs_q, rs_d;
  logic [REGW-1:0]  rt_q, rt_d;

  // One cycle of ageing: counts down and sticks at zero.
  function automatic logic [TW-1:0] tnew_age(input logic [TW-1:0] t);
    if (DECR && (t != '0)) return t - TW'(1);
    return t;
  endfunction

  // Next entry: the upstream entry (aged) or an all-zero bubble.
  always_comb begin
    dst_d  = dst_i;
    tnew_d = tnew_age(tnew_i);
    res_d  = res_i;
    rs_d   = rs_i;
    rt_d   = rt_i;
    if (bubble_i) begin
      dst_d  = '0;
      tnew_d = '0;
      res_d  = RES_NW;
      rs_d   = '0;
      rt_d   = '0;
    end
  end

  // Entry register; reset leaves a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_q  <= '0;
      tnew_q <= '0;
      res_q  <= RES_NW;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      dst_q  <= dst_d;
      tnew_q <= tnew_d;
      res_q  <= res_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end

  assign dst_o  = dst_q;
  assign tnew_o = tnew_q;
  assign res_o  = res_q;
  assign rs_o   = rs_q;
  assign rt_o   = rt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage stall/forward controller for the 5-stage MIPS pipeline. Tracks
// the producers in E, M and W and derives the stall line and every
// forwarding select combinationally from that scoreboard.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REGW = 5,
  parameter int TW   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic [REGW-1:0]  dst_d,
  input  logic [TW-1:0]    tuse_rs,
  input  logic [TW-1:0]    tuse_rt,
  input  logic [RES_W-1:0] res_d,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic [1:0]       fwd_rt_m
);

  logic [REGW-1:0]  dst_e, dst_m, dst_w;
  logic [TW-1:0]    tnew_e, tnew_m, tnew_w;
  logic [RES_W-1:0] res_e, res_m, res_w;
  logic [REGW-1:0]  rs_e, rs_m, rs_w;
  logic [REGW-1:0]  rt_e, rt_m, rt_w;

  logic [REGW-1:0]  dst_in_e;
  logic [TW-1:0]    tnew_in_e;
  logic             bubble_e;

  // Non-writing instructions enter with dst=0 so they can never match.
  assign dst_in_e  = (res_d == RES_NW) ? '0 : dst_d;
  assign tnew_in_e = TW'(tnew_of(res_d));
  // flush kills everything; a stall only replaces the instruction entering E.
  assign bubble_e  = flush | stall;

  hz_stage_reg #(.REGW(REGW), .TW(TW), .DECR(1'b0)) u_stage_e (
    .clk      (clk),
    .reset_n  (reset_n),
    .bubble_i (bubble_e),
    .dst_i    (dst_in_e),
    .tnew_i   (tnew_in_e),
    .res_i    (res_d),
    .rs_i     (rs_d),
    .rt_i     (rt_d),
    .dst_o    (dst_e),
    .tnew_o   (tnew_e),
    .res_o    (res_e),
    .rs_o     (rs_e),
    .rt_o     (rt_e)
  );

  hz_stage_reg #(.REGW(REGW), .TW(TW), .DECR(1'b1)) u_stage_m (
    .clk      (clk),
    .reset_n  (reset_n),
    .bubble_i (flush),
    .dst_i    (dst_e),
    .tnew_i   (tnew_e),
    .res_i    (res_e),
    .rs_i     (rs_e),
    .rt_i     (rt_e),
    .dst_o    (dst_m),
    .tnew_o   (tnew_m),
    .res_o    (res_m),
    .rs_o     (rs_m),
    .rt_o     (rt_m)
  );

  hz_stage_reg #(.REGW(REGW), .TW(TW), .DECR(1'b1)) u_stage_w (
    .clk      (clk),
    .reset_n  (reset_n),
    .bubble_i (flush),
    .dst_i    (dst_m),
    .tnew_i   (tnew_m),
    .res_i    (res_m),
    .rs_i     (rs_m),
    .rt_i     (rt_m),
    .dst_o    (dst_w),
    .tnew_o   (tnew_w),
    .res_o    (res_w),
    .rs_o     (rs_w),
    .rt_o     (rt_w)
  );

  // Fields carried for completeness of the entry but not needed for decisions.
  logic unused_fields;
  assign unused_fields = ^{res_e, res_m, res_w, rs_m, rs_w, rt_w};

  // A register dependency; $0 is hardwired and never creates one.
  function automatic logic hit(input logic [REGW-1:0] r, input logic [REGW-1:0] dst);
    return (r != '0) && (r == dst);
  endfunction

  // D operand: newest producer wins; if it is not ready yet, read RF (stall covers it).
  function automatic logic [1:0] sel_d(input logic [REGW-1:0] r);
    if (hit(r, dst_e)) return (tnew_e == '0) ? FWD_E : FWD_RF;
    if (hit(r, dst_m)) return (tnew_m == '0) ? FWD_M : FWD_RF;
    if (hit(r, dst_w)) return (tnew_w == '0) ? FWD_W : FWD_RF;
    return FWD_RF;
  endfunction

  // E operand: same newest-wins rule over the producers behind it.
  function automatic logic [1:0] sel_mw(input logic [REGW-1:0] r);
    if (hit(r, dst_m)) return (tnew_m == '0) ? FWD_M : FWD_RF;
    if (hit(r, dst_w)) return (tnew_w == '0) ? FWD_W : FWD_RF;
    return FWD_RF;
  endfunction

  // Stall when an E or M producer will not be ready by the time D needs it.
  always_comb begin
    stall = 1'b0;
    if ((hit(rs_d, dst_e) && (tnew_e > tuse_rs)) ||
        (hit(rt_d, dst_e) && (tnew_e > tuse_rt)) ||
        (hit(rs_d, dst_m) && (tnew_m > tuse_rs)) ||
        (hit(rt_d, dst_m) && (tnew_m > tuse_rt)))
      stall = 1'b1;
  end

  // Forwarding selects for the D, E and M consumers.
  always_comb begin
    fwd_rs_d = sel_d(rs_d);
    fwd_rt_d = sel_d(rt_d);
    fwd_rs_e = sel_mw(rs_e);
    fwd_rt_e = sel_mw(rt_e);
    fwd_rt_m = (hit(rt_m, dst_w) && (tnew_w == '0)) ? FWD_W : FWD_RF;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues one D-stage instruction
// per cycle and queues the expected outputs; a monitor compares them.
module tb_hazard_ctrl;

  localparam int REGW = 5;
  localparam int TW   = 2;

  // Result classes
  localparam int NW = 0, ALU = 1, DM = 2, PC = 3, OTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] tuse_rs, tuse_rt;
  logic [2:0] res_d;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  always #5 clk = ~clk;

  hazard_ctrl #(.REGW(REGW), .TW(TW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rs_d     (rs_d),
    .rt_d     (rt_d),
    .dst_d    (dst_d),
    .tuse_rs  (tuse_rs),
    .tuse_rt  (tuse_rt),
    .res_d    (res_d),
    .flush    (flush),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  // Reference model: the instructions occupying E (0), M (1), W (2).
  // An instruction's result exists once it has spent 'lat' cycles past E.
  typedef struct { int dst; int rs; int rt; int lat; } ins_t;
  ins_t pipe [3];

  typedef struct { string name; int sel; int val; } chk_t;
  chk_t q [$];

  int checks = 0;
  int errors = 0;
  bit last_stall = 1'b0;

  function automatic int lat_of(int res);
    if (res == DM)  return 2;
    if (res == ALU) return 1;
    return 0;
  endfunction

  function automatic int wait_left(int i);
    return (pipe[i].lat > i) ? pipe[i].lat - i : 0;
  endfunction

  function automatic bit produces(int i, int r);
    return (r != 0) && (pipe[i].dst == r);
  endfunction

  function automatic int m_stall(int rs, int rt, int urs, int urt);
    for (int i = 0; i < 2; i++)
      if ((produces(i, rs) && wait_left(i) > urs) || (produces(i, rt) && wait_left(i) > urt))
        return 1;
    return 0;
  endfunction

  // Newest producer from stage 'first' onward; its stage code if ready, else 0.
  function automatic int m_fwd(int r, int first);
    for (int i = first; i < 3; i++)
      if (produces(i, r)) return (wait_left(i) == 0) ? i + 1 : 0;
    return 0;
  endfunction

  function automatic void clear_pipe();
    for (int i = 0; i < 3; i++) pipe[i] = '{dst: 0, rs: 0, rt: 0, lat: 0};
  endfunction

  function automatic int out_of(int sel);
    case (sel)
      0: return int'(stall);
      1: return int'(fwd_rs_d);
      2: return int'(fwd_rt_d);
      3: return int'(fwd_rs_e);
      4: return int'(fwd_rt_e);
      default: return int'(fwd_rt_m);
    endcase
  endfunction

  function automatic string name_of(int sel);
    case (sel)
      0: return "stall";
      1: return "fwd_rs_d";
      2: return "fwd_rt_d";
      3: return "fwd_rs_e";
      4: return "fwd_rt_e";
      default: return "fwd_rt_m";
    endcase
  endfunction

  task automatic expect_val(input string name, input int sel, input int val);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.val  = val;
    q.push_back(c);
  endtask

  // One cycle: present an instruction in D, queue the model's view, advance the model.
  task automatic step(input int rs, input int rt, input int dst, input int urs,
                      input int urt, input int res, input bit fl, input bit rn);
    int st;
    @(negedge clk);
    rs_d    = 5'(rs);
    rt_d    = 5'(rt);
    dst_d   = 5'(dst);
    tuse_rs = 2'(urs);
    tuse_rt = 2'(urt);
    res_d   = 3'(res);
    flush   = fl;
    reset_n = rn;
    if (!rn) clear_pipe();
    st = m_stall(rs, rt, urs, urt);
    expect_val(name_of(0), 0, st);
    expect_val(name_of(1), 1, m_fwd(rs, 0));
    expect_val(name_of(2), 2, m_fwd(rt, 0));
    expect_val(name_of(3), 3, m_fwd(pipe[0].rs, 1));
    expect_val(name_of(4), 4, m_fwd(pipe[0].rt, 1));
    expect_val(name_of(5), 5, m_fwd(pipe[1].rt, 2));
    last_stall = (st != 0);
    if (rn) begin
      if (fl) clear_pipe();
      else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st != 0) pipe[0] = '{dst: 0, rs: 0, rt: 0, lat: 0};
        else         pipe[0] = '{dst: (res == NW) ? 0 : dst, rs: rs, rt: rt, lat: lat_of(res)};
      end
    end
  endtask

  task automatic ins(input int rs, input int rt, input int dst, input int urs,
                     input int urt, input int res);
    step(rs, rt, dst, urs, urt, res, 1'b0, 1'b1);
  endtask

  task automatic nop();
    step(0, 0, 0, 3, 3, NW, 1'b0, 1'b1);
  endtask

  // Monitor: compares every queued expectation shortly after the falling edge.
  initial begin
    chk_t c;
    int got;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        c = q.pop_front();
        got = out_of(c.sel);
        checks++;
        if (got !== c.val) begin
          errors++;
          $display("FAIL %s at %0t: got %0d expected %0d", c.name, $time, got, c.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int crs, crt, cdst, curs, curt, cres;
    bit fl, rn;
    reset_n = 1'b0;
    rs_d = '0; rt_d = '0; dst_d = '0; tuse_rs = 2'd3; tuse_rt = 2'd3;
    res_d = '0; flush = 1'b0;
    clear_pipe();

    // Reset state
    step(8, 8, 0, 0, 0, NW, 1'b0, 1'b0);
    expect_val("reset_stall", 0, 0);
    expect_val("reset_fwd_rs_d", 1, 0);
    nop(); nop();

    // lw $8 then dependent addu: one stall cycle
    ins(2, 8, 8, 1, 3, DM);
    ins(8, 1, 9, 1, 1, ALU);  expect_val("t1_stall", 0, 1);
    ins(8, 1, 9, 1, 1, ALU);  expect_val("t1_release", 0, 0);
    nop(); nop(); nop();

    // lw $8 then beq $8: two stall cycles, then operand from W
    ins(2, 8, 8, 1, 3, DM);
    ins(8, 0, 0, 0, 0, NW);   expect_val("t2_stall_a", 0, 1);
    ins(8, 0, 0, 0, 0, NW);   expect_val("t2_stall_b", 0, 1);
    ins(8, 0, 0, 0, 0, NW);   expect_val("t2_release", 0, 0);
                              expect_val("t2_fwd_rs_d", 1, 3);
    nop(); nop(); nop();

    // addu $8 then sw $8: no stall, store data forwarded from M in E
    ins(1, 2, 8, 1, 1, ALU);
    ins(2, 8, 0, 1, 2, NW);   expect_val("t3_stall", 0, 0);
    nop();                    expect_val("t3_fwd_rt_e", 4, 2);
    nop(); nop(); nop();

    // jal then jr $31: result already there, forward from E
    ins(0, 0, 31, 3, 3, PC);
    ins(31, 0, 0, 0, 3, NW);  expect_val("t4_stall", 0, 0);
                              expect_val("t4_fwd_rs_d", 1, 1);
    nop(); nop(); nop();

    // Writes to $0 never create a dependency
    ins(1, 0, 0, 1, 3, ALU);
    ins(0, 0, 9, 0, 0, ALU);  expect_val("t5_stall", 0, 0);
                              expect_val("t5_fwd_rs_d", 1, 0);
                              expect_val("t5_fwd_rt_d", 2, 0);
    nop(); nop(); nop();

    // Reset while stalling drops stall at once
    ins(2, 8, 8, 1, 3, DM);
    ins(8, 1, 9, 1, 1, ALU);  expect_val("t6_stall", 0, 1);
    step(8, 1, 9, 1, 1, ALU, 1'b0, 1'b0);
                              expect_val("t6_reset_stall", 0, 0);
    ins(8, 1, 9, 1, 1, ALU);  expect_val("t6_after_reset", 0, 0);
    nop(); nop(); nop();

    // Flush with lw in M: dependent sees an empty scoreboard
    ins(2, 8, 8, 1, 3, DM);
    nop();
    step(0, 0, 0, 3, 3, NW, 1'b1, 1'b1);
    ins(8, 0, 0, 0, 0, NW);   expect_val("t6_flush_stall", 0, 0);
                              expect_val("t6_flush_fwd", 1, 0);
    nop(); nop(); nop();

    // Random traffic over a few registers; D holds while stalled
    crs = 0; crt = 0; cdst = 0; curs = 3; curt = 3; cres = NW;
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) begin
        crs  = $urandom_range(0, 3);
        crt  = $urandom_range(0, 3);
        cdst = $urandom_range(0, 3);
        curs = $urandom_range(0, 3);
        curt = $urandom_range(0, 3);
        cres = $urandom_range(0, 4);
      end
      fl = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 59) != 0);
      step(crs, crt, cdst, curs, curt, cres, fl, rn);
    end
    nop();

    @(posedge clk);
    @(negedge clk);
    #4;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
